// File: rtl/fsb_trace_replay_engine.sv
// Trace-replay engine: walks a ROM program of {opcode, payload} words, sending
// payloads to a valid/ready DUT, checking its responses and timing waits.
module fsb_trace_replay_engine #(
  parameter int unsigned ring_width_p     = 32,
  parameter int unsigned rom_addr_width_p = 32
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        en_i,

  input  logic                        v_i,
  input  logic [ring_width_p-1:0]     data_i,
  output logic                        ready_o,

  output logic                        v_o,
  output logic [ring_width_p-1:0]     data_o,
  input  logic                        yumi_i,

  output logic [rom_addr_width_p-1:0] rom_addr_o,
  input  logic [ring_width_p+3:0]     rom_data_i,

  output logic                        done_o,
  output logic                        error_o
);

  typedef enum logic [3:0] {
    OP_WAIT       = 4'd0,
    OP_SEND       = 4'd1,
    OP_RECV       = 4'd2,
    OP_DONE       = 4'd3,
    OP_FINISH     = 4'd4,
    OP_CYCLE_INIT = 4'd5,
    OP_CYCLE_WAIT = 4'd6
  } op_e;

  localparam logic [rom_addr_width_p-1:0] PC_ONE  = rom_addr_width_p'(1);
  localparam logic [ring_width_p-1:0]     CNT_ONE = ring_width_p'(1);

  op_e                         op;
  logic [ring_width_p-1:0]     payload;
  logic                        active;

  logic [rom_addr_width_p-1:0] pc_q, pc_d;
  logic [ring_width_p-1:0]     cnt_q, cnt_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;

  assign op      = op_e'(rom_data_i[ring_width_p+3:ring_width_p]);
  assign payload = rom_data_i[ring_width_p-1:0];

  // reset_i is folded in so the handshakes stay low throughout reset,
  // not just after the first clock edge of it.
  assign active  = en_i & reset_i & ~done_q;

  always_comb begin
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    err_d   = err_q;
    v_o     = 1'b0;
    ready_o = 1'b0;
    if (active) begin
      case (op)
        OP_WAIT: pc_d = pc_q + PC_ONE;
        OP_SEND: begin
          v_o = 1'b1;
          if (yumi_i) pc_d = pc_q + PC_ONE;
        end
        OP_RECV: begin
          ready_o = 1'b1;
          if (v_i) begin
            if (data_i != payload) err_d = 1'b1;
            pc_d = pc_q + PC_ONE;
          end
        end
        OP_DONE, OP_FINISH: done_d = 1'b1;
        OP_CYCLE_INIT: begin
          cnt_d = payload;
          pc_d  = pc_q + PC_ONE;
        end
        OP_CYCLE_WAIT: begin
          if (cnt_q == '0) pc_d = pc_q + PC_ONE;
          else             cnt_d = cnt_q - CNT_ONE;
        end
        default: begin
          err_d = 1'b1;
          pc_d  = pc_q + PC_ONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      pc_q   <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign data_o     = payload;
  assign rom_addr_o = pc_q;
  assign done_o     = done_q;
  assign error_o    = err_q;

endmodule

// File: tb/tb_fsb_trace_replay_engine.sv
// Directed bench for fsb_trace_replay_engine with a behavioural trace ROM and
// a scoreboard of payloads expected on the send handshake.
module tb_fsb_trace_replay_engine;

  localparam int unsigned W  = 32;
  localparam int unsigned AW = 8;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b0;
  logic          en_i = 1'b1;
  logic          v_i = 1'b0;
  logic [W-1:0]  data_i = '0;
  logic          ready_o;
  logic          v_o;
  logic [W-1:0]  data_o;
  logic          yumi_i = 1'b0;
  logic [AW-1:0] rom_addr_o;
  logic [W+3:0]  rom_data_i;
  logic          done_o;
  logic          error_o;

  logic [W+3:0]  rom [256];
  logic [W-1:0]  sendq [$];

  int unsigned total = 0;
  int unsigned bad   = 0;

  assign rom_data_i = rom[rom_addr_o];

  always #5 clk_i = ~clk_i;

  fsb_trace_replay_engine #(
    .ring_width_p     (W),
    .rom_addr_width_p (AW)
  ) dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .en_i       (en_i),
    .v_i        (v_i),
    .data_i     (data_i),
    .ready_o    (ready_o),
    .v_o        (v_o),
    .data_o     (data_o),
    .yumi_i     (yumi_i),
    .rom_addr_o (rom_addr_o),
    .rom_data_i (rom_data_i),
    .done_o     (done_o),
    .error_o    (error_o)
  );

  function automatic logic [W+3:0] w(input logic [3:0] op, input logic [W-1:0] p);
    return {op, p};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_send(input string tag);
    if (sendq.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s observed=%0h expected=<none queued>", tag, data_o);
    end else begin
      chk(tag, data_o, sendq.pop_front());
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic fill_rom(input logic [3:0] op);
    for (int unsigned i = 0; i < 256; i++) rom[i] = w(op, '0);
  endtask

  task automatic do_reset(input string tag);
    reset_i = 1'b0;
    yumi_i  = 1'b0;
    v_i     = 1'b0;
    en_i    = 1'b1;
    sendq.delete();
    #1;
    chk({tag, "_rst_v"},     v_o, 0);
    chk({tag, "_rst_ready"}, ready_o, 0);
    chk({tag, "_rst_done"},  done_o, 0);
    chk({tag, "_rst_err"},   error_o, 0);
    chk({tag, "_rst_addr"},  rom_addr_o, 0);
    cyc();
    reset_i = 1'b1;
    #1;
  endtask

  initial begin
    int unsigned exp_addr [6];
    logic        recv_hs;

    // T1: send/recv/done with a matching response
    fill_rom(4'd3);
    rom[0] = w(4'd1, 32'h5);
    rom[1] = w(4'd2, 32'h20);
    rom[2] = w(4'd3, 32'h0);
    do_reset("t1");
    sendq.push_back(32'h5);
    chk("t1_c0_v", v_o, 1);
    chk("t1_c0_data", data_o, 32'h5);
    chk("t1_c0_ready", ready_o, 0);
    cyc();
    chk("t1_c1_addr", rom_addr_o, 0);
    chk("t1_c1_v", v_o, 1);
    cyc();
    chk("t1_c2_v", v_o, 1);
    yumi_i = 1'b1;
    #1;
    sb_send("t1_send");
    cyc();
    yumi_i = 1'b0;
    chk("t1_recv_addr", rom_addr_o, 1);
    chk("t1_recv_v", v_o, 0);
    chk("t1_recv_ready", ready_o, 1);
    cyc();
    chk("t1_recv_hold", rom_addr_o, 1);
    v_i = 1'b1;
    data_i = 32'h20;
    cyc();
    v_i = 1'b0;
    chk("t1_addr2", rom_addr_o, 2);
    chk("t1_err_ok", error_o, 0);
    chk("t1_done_not_yet", done_o, 0);
    cyc();
    chk("t1_done", done_o, 1);
    chk("t1_done_v", v_o, 0);
    chk("t1_done_ready", ready_o, 0);
    repeat (3) cyc();
    chk("t1_done_sticky", done_o, 1);
    chk("t1_addr_stuck", rom_addr_o, 2);
    chk("t1_err_final", error_o, 0);

    // T2: same trace, response mismatches
    do_reset("t2");
    sendq.push_back(32'h5);
    for (int unsigned k = 0; k < 30 && !done_o; k++) begin
      yumi_i = v_o && (k >= 2);
      v_i    = ready_o;
      data_i = 32'h21;
      #1;
      if (v_o && yumi_i) sb_send("t2_send");
      recv_hs = ready_o && v_i;
      cyc();
      yumi_i = 1'b0;
      v_i    = 1'b0;
      if (recv_hs) begin
        chk("t2_err_next", error_o, 1);
        chk("t2_done_next", done_o, 0);
      end
    end
    chk("t2_done", done_o, 1);
    chk("t2_err_sticky", error_o, 1);
    chk("t2_addr", rom_addr_o, 2);
    chk("t2_sb_empty", sendq.size(), 0);

    // T3: cycle counter
    fill_rom(4'd3);
    rom[0] = w(4'd5, 32'd3);
    rom[1] = w(4'd6, 32'd0);
    rom[2] = w(4'd3, 32'd0);
    do_reset("t3");
    exp_addr = '{0, 1, 1, 1, 1, 2};
    for (int unsigned i = 0; i < 6; i++) begin
      chk($sformatf("t3_addr_c%0d", i), rom_addr_o, exp_addr[i]);
      chk($sformatf("t3_done_c%0d", i), done_o, 0);
      cyc();
    end
    chk("t3_done", done_o, 1);
    chk("t3_err", error_o, 0);

    // T4: stalled send, then enable dropped
    fill_rom(4'd3);
    rom[0] = w(4'd1, 32'hA5);
    do_reset("t4");
    sendq.push_back(32'hA5);
    for (int unsigned i = 0; i < 10; i++) begin
      chk("t4_stall_v", v_o, 1);
      chk("t4_stall_addr", rom_addr_o, 0);
      cyc();
    end
    en_i = 1'b0;
    #1;
    for (int unsigned i = 0; i < 3; i++) begin
      chk("t4_dis_v", v_o, 0);
      chk("t4_dis_ready", ready_o, 0);
      chk("t4_dis_addr", rom_addr_o, 0);
      cyc();
    end
    en_i = 1'b1;
    #1;
    chk("t4_en_v", v_o, 1);
    yumi_i = 1'b1;
    #1;
    sb_send("t4_send");
    cyc();
    yumi_i = 1'b0;
    chk("t4_adv_addr", rom_addr_o, 1);
    cyc();
    chk("t4_done", done_o, 1);

    // T5: illegal opcode, WAIT, FINISH
    fill_rom(4'd3);
    rom[0] = w(4'd9, 32'h0);
    rom[1] = w(4'd0, 32'h0);
    rom[2] = w(4'd4, 32'h0);
    do_reset("t5");
    chk("t5_c0_err", error_o, 0);
    cyc();
    chk("t5_c1_addr", rom_addr_o, 1);
    chk("t5_c1_err", error_o, 1);
    cyc();
    chk("t5_c2_addr", rom_addr_o, 2);
    chk("t5_c2_done", done_o, 0);
    cyc();
    chk("t5_finish_done", done_o, 1);
    chk("t5_finish_addr", rom_addr_o, 2);
    chk("t5_err_sticky", error_o, 1);

    // T6: reset asserted in the middle of a send
    fill_rom(4'd3);
    rom[0] = w(4'd9, 32'h0);
    rom[1] = w(4'd1, 32'h11);
    rom[2] = w(4'd1, 32'h22);
    do_reset("t6");
    sendq.push_back(32'h11);
    cyc();
    chk("t6_c1_addr", rom_addr_o, 1);
    chk("t6_c1_err", error_o, 1);
    chk("t6_c1_v", v_o, 1);
    yumi_i = 1'b1;
    #1;
    sb_send("t6_send");
    cyc();
    yumi_i = 1'b0;
    chk("t6_c2_addr", rom_addr_o, 2);
    chk("t6_c2_v", v_o, 1);
    chk("t6_c2_data", data_o, 32'h22);
    reset_i = 1'b0;
    #1;
    chk("t6_async_v", v_o, 0);
    chk("t6_async_addr", rom_addr_o, 0);
    chk("t6_async_err", error_o, 0);
    chk("t6_async_done", done_o, 0);
    cyc();
    reset_i = 1'b1;
    #1;
    chk("t6_rel_addr", rom_addr_o, 0);
    chk("t6_rel_err", error_o, 0);
    cyc();
    chk("t6_replay_addr", rom_addr_o, 1);
    chk("t6_replay_v", v_o, 1);
    chk("t6_replay_data", data_o, 32'h11);
    chk("t6_replay_err", error_o, 1);

    // T7: program counter wraps
    fill_rom(4'd0);
    do_reset("t7");
    repeat (255) cyc();
    chk("t7_addr_255", rom_addr_o, 255);
    cyc();
    chk("t7_addr_wrap", rom_addr_o, 0);
    cyc();
    chk("t7_addr_after", rom_addr_o, 1);
    chk("t7_done", done_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fsb_trace_replay_engine.md
Name: fsb_trace_replay_engine

Overview:
- Synthesizable trace-replay engine that drives and checks a valid/ready stream DUT from a ROM program.
- Each ROM word holds a 4-bit opcode and a ring_width_p payload.
- The engine steps through the ROM: it sends payloads to the DUT, receives DUT outputs and compares them to expected payloads, waits cycles, and flags done or error.
- It sits in simulation benches between an external trace ROM and the block under test.

Parameters:
- ring_width_p, 32: payload/data width.
- rom_addr_width_p, 32: ROM address width.
- Derived: rom data width = ring_width_p+4.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  asynchronous, active-low reset (0 = reset asserted).
- en_i  in  1  enable; 0 freezes the engine.
- v_i  in  1  valid from DUT output.
- data_i  in  ring_width_p  DUT output data.
- ready_o  out  1  engine accepts v_i/data_i this cycle.
- v_o  out  1  valid of data to DUT.
- data_o  out  ring_width_p  data to DUT (payload of current word).
- yumi_i  in  1  DUT consumes data_o this cycle; legal only when v_o=1.
- rom_addr_o  out  rom_addr_width_p  current ROM address (registered program counter).
- rom_data_i  in  ring_width_p+4  ROM word at rom_addr_o; combinational ROM, same cycle.
- done_o  out  1  trace finished (sticky).
- error_o  out  1  mismatch or illegal opcode seen (sticky).

Behaviour:
- Decode: op = rom_data_i[ring_width_p+3:ring_width_p], payload = rom_data_i[ring_width_p-1:0]. data_o = payload at all times.
- Reset (reset_i=0, asynchronous): pc=0, cycle counter=0, done=0, error=0. v_o=0, ready_o=0, done_o=0, error_o=0 while in reset. After release, execution starts at address 0.
- Gating: v_o and ready_o are 0 whenever en_i=0 or done=1. No state changes in those conditions.
- Opcodes, with en_i=1 and not done:
  - 0 WAIT: pc+1 next cycle.
  - 1 SEND: v_o=1; pc+1 on the cycle yumi_i=1; otherwise hold.
  - 2 RECV: ready_o=1. On the cycle v_i=1: compare data_i to payload; if unequal, error←1; pc+1. Otherwise hold.
  - 3 DONE: done←1; pc holds; done_o stays 1 until reset.
  - 4 FINISH: same as DONE. It is additionally the hook for bench termination and must still be synthesizable; no $finish inside the RTL.
  - 5 CYCLE_INIT: counter←payload; pc+1.
  - 6 CYCLE_WAIT: if counter==0, pc+1; else counter−1 and hold.
  - 7–15: illegal; error←1, pc+1.
- One instruction per cycle at most. Latency of any advancing op is 1 cycle from its handshake to the next word appearing on rom_addr_o.
- error_o is sticky and does not stop execution.
- pc wraps modulo 2^rom_addr_width_p.
- Payload compare is the full ring_width_p bits; no masking.
- SEND and RECV never both active; only the current op drives a handshake.
- Reset mid-trace: all state cleared immediately; replay restarts from address 0 after release.

Test Plan:
- ROM {SEND 0x5, RECV 0x20, DONE}. DUT yumis at cycle 2 and returns 0x20. Expected: v_o=1 with data_o=5 until yumi; ready_o=1 until v_i; then done_o=1, error_o=0, rom_addr_o stuck at 2.
- Same ROM, DUT returns 0x21. Expected: error_o=1 from the cycle after the compare, done_o=1 afterwards.
- ROM {CYCLE_INIT 3, CYCLE_WAIT, DONE}. Expected: CYCLE_WAIT occupies 4 cycles (counter 3→0, then advance), then done_o=1.
- SEND with yumi_i held 0 for 10 cycles, then en_i=0 for 3 cycles. Expected: pc holds; v_o drops to 0 during en_i=0; advance on the first yumi after en_i returns to 1.
- ROM word with opcode 9. Expected: error_o=1, pc advances to next word.
- Assert reset_i=0 mid-SEND. Expected: asynchronously v_o=0, rom_addr_o=0, error_o=0, done_o=0; on release, replay restarts at word 0.
